// File: rtl/cam_capture_ctrl.sv
// Camera frame capture sequencer: packs href-qualified byte pairs into RGB565 pixels,
// writes them into the line FIFO and concurrently drains the FIFO into the frame buffer.
module cam_capture_ctrl #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_din,
    input  logic              i_fifo_full,
    input  logic              i_fifo_empty,
    input  logic [15:0]       i_fifo_dout,
    output logic              o_fifo_clr,
    output logic              o_fifo_wr,
    output logic [15:0]       o_fifo_din,
    output logic              o_fifo_rd,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);

    localparam int X_W = $clog2(H_PIXELS + 1);
    localparam int Y_W = $clog2(V_LINES + 1);

    localparam logic [X_W-1:0]    X_MAX    = X_W'(H_PIXELS);
    localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(V_LINES);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    logic [1:0]        r_state;
    logic              r_vs_d;
    logic              r_hr_d;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_fifo_clr;
    logic              r_fifo_wr;
    logic [15:0]       r_fifo_din;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_done;
    logic              r_overflow;

    logic w_busy;
    logic w_vs_fall;
    logic w_vs_rise;
    logic w_hr_fall;
    logic w_pix_keep;
    logic w_fifo_rd;
    logic w_flush_done;

    assign w_busy     = (r_state != S_IDLE);
    assign w_vs_fall  = r_vs_d & ~i_vsync;
    assign w_vs_rise  = ~r_vs_d & i_vsync;
    assign w_hr_fall  = r_hr_d & ~i_href;
    assign w_pix_keep = (r_x < X_MAX) && (r_y < Y_MAX);

    // r_mem_we is the previous cycle's read, so reads alternate; no read while the clear lands.
    assign w_fifo_rd    = w_busy & ~i_fifo_empty & ~r_mem_we & ~r_fifo_clr;
    assign w_flush_done = i_fifo_empty & ~r_mem_we & ~r_fifo_wr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_vs_d     <= 1'b0;
            r_hr_d     <= 1'b0;
            r_phase    <= 1'b0;
            r_hi       <= 8'h00;
            r_x        <= '0;
            r_y        <= '0;
            r_fifo_clr <= 1'b0;
            r_fifo_wr  <= 1'b0;
            r_fifo_din <= 16'h0000;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are raised below; last non-blocking write wins.
            r_vs_d     <= i_vsync;
            r_hr_d     <= i_href;
            r_fifo_clr <= 1'b0;
            r_fifo_wr  <= 1'b0;
            r_done     <= 1'b0;
            r_mem_we   <= w_fifo_rd;
            if (r_mem_we && (r_mem_addr != ADDR_MAX)) begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_WAIT_VS;
                        r_fifo_clr <= 1'b1;
                        r_overflow <= 1'b0;
                        r_mem_addr <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_phase    <= 1'b0;
                    end
                end
                S_WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_rise || (r_y == Y_MAX)) begin
                        r_state <= S_FLUSH;
                    end
                    if (w_hr_fall) begin
                        if (r_y != Y_MAX) begin
                            r_y <= r_y + 1'b1;
                        end
                        r_x     <= '0;
                        r_phase <= 1'b0;
                    end else if (i_href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_hi <= i_din;
                        end else begin
                            if (r_x != X_MAX) begin
                                r_x <= r_x + 1'b1;
                            end
                            if (w_pix_keep) begin
                                if (i_fifo_full) begin
                                    r_overflow <= 1'b1;
                                end else begin
                                    r_fifo_wr  <= 1'b1;
                                    r_fifo_din <= {r_hi, i_din};
                                end
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_flush_done) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fifo_clr = r_fifo_clr;
    assign o_fifo_wr  = r_fifo_wr;
    assign o_fifo_din = r_fifo_din;
    assign o_fifo_rd  = w_fifo_rd;
    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_we ? i_fifo_dout : 16'h0000;
    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: behavioural FIFO, pixel scoreboard, table of frame
// scenarios plus hand-written reset / busy-start / coincident-edge sequences.
module tb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_dout = 16'h0000;
    logic          fifo_clr;
    logic          fifo_wr;
    logic [15:0]   fifo_din;
    logic          fifo_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_vsync      (vsync),
        .i_href       (href),
        .i_din        (din),
        .i_fifo_full  (fifo_full),
        .i_fifo_empty (fifo_empty),
        .i_fifo_dout  (fifo_dout),
        .o_fifo_clr   (fifo_clr),
        .o_fifo_wr    (fifo_wr),
        .o_fifo_din   (fifo_din),
        .o_fifo_rd    (fifo_rd),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_overflow   (overflow)
    );

    // Line FIFO: 16 deep, registered read data, not affected by the controller reset.
    logic [15:0] f_mem [16];
    logic [3:0]  f_wp = 4'd0;
    logic [3:0]  f_rp = 4'd0;
    logic [4:0]  f_cnt = 5'd0;
    logic        force_full = 1'b0;
    logic        f_do_wr;
    logic        f_do_rd;

    assign fifo_full  = force_full | (f_cnt == 5'd16);
    assign fifo_empty = (f_cnt == 5'd0);
    assign f_do_wr    = fifo_wr & ~fifo_full;
    assign f_do_rd    = fifo_rd & ~fifo_empty;

    always @(posedge clk) begin
        if (fifo_clr) begin
            f_wp  <= 4'd0;
            f_rp  <= 4'd0;
            f_cnt <= 5'd0;
        end else begin
            if (f_do_wr) begin
                f_mem[f_wp] <= fifo_din;
                f_wp        <= f_wp + 4'd1;
            end
            if (f_do_rd) begin
                fifo_dout <= f_mem[f_rp];
                f_rp      <= f_rp + 4'd1;
            end
            f_cnt <= f_cnt + {4'd0, f_do_wr} - {4'd0, f_do_rd};
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int mem_idx = 0;
    logic [15:0] exp_wr_q[$];
    logic [15:0] exp_mem_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: pixels are queued as they are driven and popped as the DUT emits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_clr) begin
                clr_cnt++;
                mem_idx = 0;
            end
            if (fifo_wr) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL fifo_wr_unexpected: got fifo_din=0x%0h, no pixel pending", fifo_din);
                end else begin
                    check("fifo_din", 64'(fifo_din), 64'(exp_wr_q.pop_front()));
                end
            end
            if (mem_we) begin
                if (exp_mem_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_we_unexpected: got mem_data=0x%0h, no pixel pending", mem_data);
                end else begin
                    check("mem_data", 64'(mem_data), 64'(exp_mem_q.pop_front()));
                    check("mem_addr", 64'(mem_addr), 64'(mem_idx));
                end
                mem_idx++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    function automatic logic [7:0] bval(input int l, input int k);
        return 8'(32'h10 + 32 * l + k);
    endfunction

    // One href line; full_pix forces fifo_full on that pixel of line 0; cap=0 expects no capture.
    task automatic send_line(input int l, input int nbytes, input int full_pix, input bit cap);
        for (int k = 0; k < nbytes; k++) begin
            din        = bval(l, k);
            href       = 1'b1;
            force_full = (l == 0) && (k % 2 == 1) && (k / 2 == full_pix);
            if (cap && (k % 2 == 1) && (l < V) && (k / 2 < H) && !force_full) begin
                exp_wr_q.push_back({bval(l, k - 1), bval(l, k)});
                exp_mem_q.push_back({bval(l, k - 1), bval(l, k)});
            end
            tick();
        end
        href       = 1'b0;
        din        = 8'h00;
        force_full = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_done(input int target);
        int i;
        i = 0;
        while ((done_cnt < target) && (i < 400)) begin
            tick();
            i++;
        end
        check("done_within_budget", 64'(done_cnt >= target), 64'd1);
    endtask

    typedef struct {
        int lines;
        int nbytes;
        int full_pix;
        int exp_wr;
        bit exp_ovf;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   wr0;
        int   d0;
        int   c0;

        vecs[0] = '{2, 8,  -1, 8, 1'b0};  // basic 4x2 frame
        vecs[1] = '{2, 12, -1, 8, 1'b0};  // long lines truncated to H
        vecs[2] = '{2, 8,   1, 7, 1'b1};  // second pixel dropped on fifo_full
        vecs[3] = '{1, 8,  -1, 4, 1'b0};  // vsync rises after one line
        vecs[4] = '{3, 8,  -1, 8, 1'b0};  // extra line after V lines ignored
        vecs[5] = '{2, 7,  -1, 6, 1'b0};  // odd trailing byte discarded

        // Reset: outputs quiet even with start held.
        start = 1'b1;
        repeat (5) tick();
        check("reset_outputs",
              {17'd0, fifo_clr, fifo_wr, fifo_din, fifo_rd, mem_we, mem_addr, mem_data, busy, done, overflow},
              64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_reset_busy", 64'(busy), 64'd0);
        check("idle_after_reset_done", 64'(done_cnt), 64'd0);

        for (int i = 0; i < 6; i++) begin
            wr0 = wr_cnt;
            d0  = done_cnt;
            c0  = clr_cnt;
            pulse_start();
            check($sformatf("v%0d_ovf_cleared", i), 64'(overflow), 64'd0);
            check($sformatf("v%0d_busy_start", i), 64'(busy), 64'd1);
            vsync_pulse();
            for (int l = 0; l < vecs[i].lines; l++) begin
                send_line(l, vecs[i].nbytes, vecs[i].full_pix, 1'b1);
            end
            vsync = 1'b1;
            wait_done(d0 + 1);
            repeat (4) tick();
            vsync = 1'b0;
            tick();
            check($sformatf("v%0d_wr_count", i), 64'(wr_cnt - wr0), 64'(vecs[i].exp_wr));
            check($sformatf("v%0d_overflow", i), 64'(overflow), 64'(vecs[i].exp_ovf));
            check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].exp_wr));
            check($sformatf("v%0d_done_once", i), 64'(done_cnt - d0), 64'd1);
            check($sformatf("v%0d_clr_once", i), 64'(clr_cnt - c0), 64'd1);
            check($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
            check($sformatf("v%0d_sb_drained", i), 64'(exp_wr_q.size() + exp_mem_q.size()), 64'd0);
        end

        // start while busy is ignored; reset mid-capture returns to IDLE without done.
        c0 = clr_cnt;
        d0 = done_cnt;
        pulse_start();
        tick();
        pulse_start();
        repeat (2) tick();
        check("busy_start_ignored_wait", 64'(clr_cnt - c0), 64'd1);
        vsync_pulse();
        pulse_start();
        check("busy_start_ignored_capture", 64'(clr_cnt - c0), 64'd1);
        check("busy_in_capture", 64'(busy), 64'd1);
        for (int k = 0; k < 5; k++) begin
            din  = bval(0, k);
            href = 1'b1;
            if (k % 2 == 1) begin
                exp_wr_q.push_back({bval(0, k - 1), bval(0, k)});
                exp_mem_q.push_back({bval(0, k - 1), bval(0, k)});
            end
            tick();
        end
        rst_n = 1'b0;
        href  = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        tick();
        check("reset_idle_next_edge", 64'(busy), 64'd0);
        check("reset_pixels_written", 64'(exp_wr_q.size()), 64'd0);
        exp_wr_q.delete();
        exp_mem_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_drain", 64'(fifo_rd), 64'd0);
        repeat (3) tick();
        check("reset_no_done", 64'(done_cnt - d0), 64'd0);

        // start and vs_fall in the same IDLE cycle: that fall must not open capture.
        vsync = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        vsync = 1'b0;
        tick();
        start = 1'b0;
        wr0 = wr_cnt;
        d0  = done_cnt;
        send_line(0, 8, -1, 1'b0);
        check("coincident_fall_no_capture", 64'(wr_cnt - wr0), 64'd0);
        check("coincident_fall_busy", 64'(busy), 64'd1);
        vsync_pulse();
        send_line(0, 8, -1, 1'b1);
        vsync = 1'b1;
        wait_done(d0 + 1);
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        check("recover_wr_count", 64'(wr_cnt - wr0), 64'd4);
        check("recover_mem_addr", 64'(mem_addr), 64'd4);
        check("recover_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
